exec_unit_icon_tx: RTL
======================

// Module: exec_unit_icon_tx
// PURPOSE
//  Transmit end of the exec-unit result path. Accepts ALPU results (type_alpu_channel_tx) and buffers them in order.
//  Each result goes to one of two places:
//  - the local x-cache write port, when the destination is this EU and the result is not an output;
//  - the interconnect channel (type_icon_channel, valid/ready), for all other destinations.
//  Sits between the ALPU tx side and the icon/xcache receivers; the ALPU is back-pressured when the buffer is full.
// PARAMETERS
//  EU_IDX      0  index of this exec unit; compared against opd_addr.eu_idx
//  FIFO_DEPTH  4  result buffer entries; power of two, >=2
// PORTS
//  i_clk               in   1       single clock, all state on rising edge
//  i_reset             in   1       synchronous, active-high reset
//  i_alpu_tx           in   $bits(type_alpu_channel_tx)  ALPU result: opd_data, opd_addr, opd_opx, opd_valid
//  o_alpu_tx_ready     out  1       buffer can accept a result this cycle
//  o_icon_tx           out  $bits(type_icon_channel)     addr, data, valid to interconnect
//  i_icon_rx           in   $bits(type_icon_rx_channel)  ready from interconnect
//  o_icon_opx          out  1       opx sideband accompanying o_icon_tx
//  o_lwr_valid         out  1       local x-cache write request
//  o_lwr_addr          out  $bits(type_alpu_local_addr)  local reg_idx
//  o_lwr_data          out  $bits(type_exec_unit_data)   write data
//  o_lwr_opx           out  1       selects the op0 or op1 x buffer
//  i_lwr_ready         in   1       x-cache accepts the write (has_been_read set on target)
//  o_count             out  $clog2(FIFO_DEPTH+1)          current occupancy
// BEHAVIOUR
//  Reset: count=0, rd/wr pointers=0. o_icon_tx.valid=0, o_lwr_valid=0, o_alpu_tx_ready=1.
//   Storage contents are don't-care. Reset mid-transfer discards all buffered entries, with no handshake completed that cycle.
//  Push: opd_valid && o_alpu_tx_ready at edge N. Store {opd_addr, opd_data, opd_opx} at wr_ptr; wr_ptr++.
//  o_alpu_tx_ready = (count < FIFO_DEPTH). It is a function of registered count only, with no comb path from any ready input.
//  When full, no push occurs even if a pop happens in the same cycle (no pass-through).
//  Latency: an entry pushed at edge N is presented at the head from cycle N+1; it is never forwarded in the same cycle it is pushed.
//  Head classification: local = !head.addr.is_output && (head.addr.eu_idx == EU_IDX); remote = !local.
//  o_lwr_valid = (count!=0) && local.   o_icon_tx.valid = (count!=0) && remote.  The two are never high together.
//  Pop: (o_lwr_valid && i_lwr_ready) || (o_icon_tx.valid && i_icon_rx.ready). On pop, rd_ptr++.
//  Strict in-order: a stalled head blocks younger entries, including entries bound for the other port.
//  While valid, the head fields are held stable until accepted; valid never drops without a handshake.
//  When a valid is low, the corresponding addr/data/opx outputs are driven 0.
//  o_icon_tx.addr carries the full type_exec_unit_addr, is_output included; o_icon_opx = head opx.
//  o_lwr_addr = head.addr.reg_idx.
//  Simultaneous push and pop: count unchanged and both pointers advance.
//  Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count saturates in [0, FIFO_DEPTH] by construction.
//  Assertions: push never occurs when count==FIFO_DEPTH; pop never occurs when count==0; lwr_valid and icon valid are never both 1.
// STRUCTURE
//  exec_unit_dtypes additions:
//  - type_icon_tx_entry {type_exec_unit_addr addr; type_exec_unit_data data; logic opx;}
//  - ICON_TX_FIFO_DEPTH default constant.
//  Sub-module: exec_unit_sync_fifo (generic, parameterised on entry type and depth; push/pop/full/empty/count).
//  It is reusable by the iqueue. Top level contains only head classification, valid/ready steering and output zeroing.
// TESTING
//  1 Reset, no stimulus -> ready=1, both valids 0, count=0 for 10 cycles; outputs all 0.
//  2 Push remote result (eu_idx=1, reg=3, data=0xA5), icon ready=1 -> icon valid in the next cycle with those fields.
//    Popped that cycle; count returns to 0.
//  3 Push local result (eu_idx=0, is_output=0, reg=2, opx=1, data=0x3C), lwr_ready=0 for 3 cycles then 1.
//    -> lwr_valid held 4 cycles with stable fields; pops on cycle 4.
//  4 Push 4 remote results with icon ready=0 -> count=4, ready=0; a 5th opd_valid is not taken.
//    Raise ready -> the 4 entries leave in push order.
//  5 Local entry stalled at head, remote entry behind it -> icon valid stays 0 until local accepted.
//    Then the remote entry is presented the next cycle.
//  6 Steady push+pop every cycle at count=2 -> count constant 2, data order preserved.
//    Assert i_reset mid-stream -> count=0 and valids 0 the next cycle.

Source files
------------

// File: rtl/exec_unit_icon_tx_pkg.sv
// Exec-unit result-path datatypes shared by the ALPU tx side, the icon tx buffer and the x-cache.
// Latency: n/a (types, constants and a classification helper only).
// Backpressure: n/a.
package exec_unit_icon_tx_pkg;

  localparam int EU_IDX_W           = 2;
  localparam int REG_IDX_W          = 4;
  localparam int DATA_W             = 16;
  localparam int ICON_TX_FIFO_DEPTH = 4;

  typedef logic [DATA_W-1:0]    type_exec_unit_data;
  typedef logic [REG_IDX_W-1:0] type_alpu_local_addr;

  typedef struct packed {
    logic                  is_output;
    logic [EU_IDX_W-1:0]   eu_idx;
    type_alpu_local_addr   reg_idx;
  } type_exec_unit_addr;

  typedef struct packed {
    type_exec_unit_data opd_data;
    type_exec_unit_addr opd_addr;
    logic               opd_opx;
    logic               opd_valid;
  } type_alpu_channel_tx;

  typedef struct packed {
    type_exec_unit_addr addr;
    type_exec_unit_data data;
    logic               valid;
  } type_icon_channel;

  typedef struct packed {
    logic ready;
  } type_icon_rx_channel;

  typedef struct packed {
    type_exec_unit_addr addr;
    type_exec_unit_data data;
    logic               opx;
  } type_icon_tx_entry;

  // A result stays in this EU only when it targets this EU and is not a program output.
  function automatic logic is_local_dest(input type_exec_unit_addr a,
                                         input logic [EU_IDX_W-1:0] eu_idx);
    return !a.is_output && (a.eu_idx == eu_idx);
  endfunction

endpackage

// File: rtl/exec_unit_sync_fifo.sv
// Generic synchronous FIFO, parameterised on entry type and power-of-two depth.
// Latency: an entry pushed at edge N is visible at head from cycle N+1 (no fall-through).
// Backpressure: caller must not push when full or pop when empty; such requests are ignored.
//
// Ports: clk, reset (sync, active-high), push/push_data, pop, head (oldest entry),
//        full, empty, count (occupancy 0..DEPTH).
module exec_unit_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/exec_unit_icon_tx.sv
// Buffers ALPU results in order and steers each head entry to the local x-cache or the interconnect.
// Latency: a result accepted at edge N is presented on exactly one output port from cycle N+1.
// Backpressure: o_alpu_tx_ready drops when the buffer is full; a stalled head blocks all younger entries.
//
// Ports: i_clk/i_reset (sync, active-high); i_alpu_tx/o_alpu_tx_ready (ALPU result in);
//        o_icon_tx/o_icon_opx/i_icon_rx (interconnect out, valid/ready);
//        o_lwr_valid/o_lwr_addr/o_lwr_data/o_lwr_opx/i_lwr_ready (local x-cache write); o_count (occupancy).
module exec_unit_icon_tx
  import exec_unit_icon_tx_pkg::*;
#(
  parameter int EU_IDX     = 0,
  parameter int FIFO_DEPTH = ICON_TX_FIFO_DEPTH
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  type_alpu_channel_tx              i_alpu_tx,
  output logic                             o_alpu_tx_ready,
  output type_icon_channel                 o_icon_tx,
  input  type_icon_rx_channel              i_icon_rx,
  output logic                             o_icon_opx,
  output logic                             o_lwr_valid,
  output type_alpu_local_addr              o_lwr_addr,
  output type_exec_unit_data               o_lwr_data,
  output logic                             o_lwr_opx,
  input  logic                             i_lwr_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_count
);

  localparam logic [EU_IDX_W-1:0] MY_EU = EU_IDX_W'(EU_IDX);

  type_icon_tx_entry push_entry;
  type_icon_tx_entry head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              head_local;
  logic              lwr_valid;
  logic              icon_valid;

  assign push_entry.addr = i_alpu_tx.opd_addr;
  assign push_entry.data = i_alpu_tx.opd_data;
  assign push_entry.opx  = i_alpu_tx.opd_opx;

  // Ready depends only on registered occupancy, so a full buffer refuses a push even
  // when the head is leaving this same cycle.
  assign o_alpu_tx_ready = !full;
  assign push            = i_alpu_tx.opd_valid && o_alpu_tx_ready;

  exec_unit_sync_fifo #(
    .T     (type_icon_tx_entry),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (o_count)
  );

  assign head_local = is_local_dest(head.addr, MY_EU);
  assign lwr_valid  = !empty && head_local;
  assign icon_valid = !empty && !head_local;
  assign pop        = (lwr_valid && i_lwr_ready) || (icon_valid && i_icon_rx.ready);

  // Payload outputs are forced to zero whenever their valid is low.
  always_comb begin
    o_icon_tx   = '0;
    o_icon_opx  = 1'b0;
    o_lwr_valid = lwr_valid;
    o_lwr_addr  = '0;
    o_lwr_data  = '0;
    o_lwr_opx   = 1'b0;
    if (icon_valid) begin
      o_icon_tx.addr  = head.addr;
      o_icon_tx.data  = head.data;
      o_icon_tx.valid = 1'b1;
      o_icon_opx      = head.opx;
    end
    if (lwr_valid) begin
      o_lwr_addr = head.addr.reg_idx;
      o_lwr_data = head.data;
      o_lwr_opx  = head.opx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(lwr_valid && icon_valid));
    end
  end

endmodule
